// File: rtl/mips_debug_ctrl.sv
// UART debug sequencer for the MIPS core: load program, run, single-step, dump registers.
// Optional `DEBUG_TIMEOUT_EN adds an inter-byte timeout while loading.
module mips_debug_ctrl #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int NUM_REGISTERS   = 32,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter int REG_ADDR_WIDTH  = $clog2(NUM_REGISTERS),
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_done,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_imem_we,
  output logic [ADDR_WIDTH-1:0]     o_imem_addr,
  output logic [SIZE-1:0]           o_imem_wdata,
  output logic [REG_ADDR_WIDTH-1:0] o_reg_addr,
  input  logic [SIZE-1:0]           i_reg_data,
  input  logic [SIZE-1:0]           i_pc,
  input  logic                      i_halt,
  output logic                      o_cpu_stall,
  output logic                      o_cpu_rst,
  output logic                      o_prog_loaded,
  output logic [2:0]                o_state
);
  // state | meaning: IDLE dispatch, LOAD receive program, RUN free-run, STEP one cycle, DUMP read reg, TX send reply
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3,
                            S_DUMP = 3'd4, S_TX = 3'd5} state_t;

  localparam int BYTES = SIZE / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TCW   = $clog2(BYTES + 1);
  localparam logic [7:0] CMD_L = 8'h4C, CMD_R = 8'h52, CMD_S = 8'h53, CMD_D = 8'h44, CMD_P = 8'h50;
  localparam logic [7:0] RSP_ERR = 8'hEE, RSP_OK = 8'h4B, RSP_TMO = 8'hEF;

  state_t state, state_n;
  logic            ph, ph_n, ret_dump, ret_dump_n, tx_wait, tx_wait_n;
  logic [SIZE-1:0] tx_buf, tx_buf_n;
  logic [TCW-1:0]  tx_cnt, tx_cnt_n;
  logic [7:0]      words_left, words_left_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, imem_addr_n;
  logic [BCW-1:0]  byte_cnt, byte_cnt_n;
  logic [SIZE-9:0] shift, shift_n;
  logic [7:0]      tx_data_n;
  logic [SIZE-1:0] imem_wdata_n;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_n;
  logic tx_start_n, imem_we_n, stall_n, cpu_rst_n, prog_loaded_n;
  logic n_ok, last_byte, last_word, run_stop, tx_last, dump_last, tmo_hit;

  assign n_ok      = (i_rx_data != 8'd0) && (int'(i_rx_data) <= MAX_INSTRUCTION);
  assign last_byte = (byte_cnt == BCW'(BYTES - 1));
  assign last_word = (words_left == 8'd1);
  assign run_stop  = i_halt || (i_rx_done && (i_rx_data == CMD_P));
  assign tx_last   = (tx_cnt == TCW'(1));
  assign dump_last = (o_reg_addr == REG_ADDR_WIDTH'(NUM_REGISTERS - 1));
  assign o_state   = state;

`ifdef DEBUG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;

  // Reloads on every received byte and whenever LOAD is not active.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             tmo_cnt <= '0;
    else if (state != S_LOAD || i_rx_done) tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)                tmo_cnt <= tmo_cnt - 1'b1;
  end
  assign tmo_hit = (state == S_LOAD) && !i_rx_done && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;       ph <= 1'b0;         ret_dump <= 1'b0;
      tx_wait <= 1'b0;       tx_buf <= '0;       tx_cnt <= '0;
      words_left <= '0;      wr_addr <= '0;      byte_cnt <= '0;      shift <= '0;
      o_tx_data <= '0;       o_tx_start <= 1'b0; o_imem_we <= 1'b0;
      o_imem_addr <= '0;     o_imem_wdata <= '0; o_reg_addr <= '0;
      o_cpu_stall <= 1'b1;   o_cpu_rst <= 1'b0;  o_prog_loaded <= 1'b0;
    end else begin
      state <= state_n;      ph <= ph_n;         ret_dump <= ret_dump_n;
      tx_wait <= tx_wait_n;  tx_buf <= tx_buf_n; tx_cnt <= tx_cnt_n;
      words_left <= words_left_n; wr_addr <= wr_addr_n; byte_cnt <= byte_cnt_n; shift <= shift_n;
      o_tx_data <= tx_data_n; o_tx_start <= tx_start_n; o_imem_we <= imem_we_n;
      o_imem_addr <= imem_addr_n; o_imem_wdata <= imem_wdata_n; o_reg_addr <= reg_addr_n;
      o_cpu_stall <= stall_n; o_cpu_rst <= cpu_rst_n; o_prog_loaded <= prog_loaded_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (i_rx_done) begin
        case (i_rx_data)
          CMD_L:   state_n = S_LOAD;
          CMD_R:   state_n = o_prog_loaded ? S_RUN : S_TX;
          CMD_S:   state_n = (o_prog_loaded && !i_halt) ? S_STEP : S_TX;
          CMD_D:   state_n = S_DUMP;
          default: state_n = S_TX;
        endcase
      end
      S_LOAD: begin
        if (tmo_hit) state_n = S_TX;
        else if (i_rx_done && ((!ph && !n_ok) || (ph && last_byte && last_word))) state_n = S_TX;
      end
      S_RUN, S_STEP, S_DUMP: if (ph) state_n = S_TX;
      S_TX: if (tx_wait && i_tx_done && tx_last) state_n = (ret_dump && !dump_last) ? S_DUMP : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    logic            rep_en, wrep_en;
    logic [7:0]      rep_byte;
    logic [SIZE-1:0] wrep_word;
    rep_en = 1'b0;  rep_byte = RSP_ERR;  wrep_en = 1'b0;  wrep_word = '0;
    ph_n = ph;  ret_dump_n = ret_dump;  tx_wait_n = tx_wait;  tx_buf_n = tx_buf;  tx_cnt_n = tx_cnt;
    words_left_n = words_left;  wr_addr_n = wr_addr;  byte_cnt_n = byte_cnt;  shift_n = shift;
    tx_data_n = o_tx_data;  tx_start_n = 1'b0;  imem_we_n = 1'b0;  imem_addr_n = o_imem_addr;
    imem_wdata_n = o_imem_wdata;  reg_addr_n = o_reg_addr;  stall_n = 1'b1;  cpu_rst_n = 1'b0;
    prog_loaded_n = o_prog_loaded;
    case (state)
      S_IDLE: if (i_rx_done) begin
        ph_n = 1'b0;
        case (i_rx_data)
          CMD_L: ;
          CMD_R: if (!o_prog_loaded) rep_en = 1'b1;
                 else begin ph_n = i_halt; stall_n = i_halt; end
          CMD_S: if (!o_prog_loaded || i_halt) rep_en = 1'b1;
                 else stall_n = 1'b0;
          CMD_D: ;
          default: rep_en = 1'b1;
        endcase
      end
      S_LOAD: begin
        if (tmo_hit) begin
          prog_loaded_n = 1'b0;  rep_en = 1'b1;  rep_byte = RSP_TMO;
        end else if (i_rx_done && !ph) begin
          if (!n_ok) rep_en = 1'b1;
          else begin
            words_left_n = i_rx_data;  cpu_rst_n = 1'b1;  prog_loaded_n = 1'b0;
            ph_n = 1'b1;  byte_cnt_n = '0;  wr_addr_n = '0;
          end
        end else if (i_rx_done) begin
          shift_n = {shift[SIZE-17:0], i_rx_data};
          byte_cnt_n = byte_cnt + 1'b1;
          if (last_byte) begin
            byte_cnt_n = '0;  imem_we_n = 1'b1;  imem_addr_n = wr_addr;
            imem_wdata_n = {shift, i_rx_data};
            wr_addr_n = wr_addr + 1'b1;  words_left_n = words_left - 8'd1;
            if (last_word) begin prog_loaded_n = 1'b1;  rep_en = 1'b1;  rep_byte = RSP_OK; end
          end
        end
      end
      S_RUN: begin
        if (ph) begin wrep_en = 1'b1;  wrep_word = i_pc; end
        else if (run_stop) ph_n = 1'b1;
        else stall_n = 1'b0;
      end
      S_STEP: begin
        if (ph) begin wrep_en = 1'b1;  wrep_word = i_pc; end
        else ph_n = 1'b1;
      end
      S_DUMP: begin
        if (ph) begin wrep_en = 1'b1;  wrep_word = i_reg_data; end
        else ph_n = 1'b1;
      end
      S_TX: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;  tx_data_n = tx_buf[SIZE-1 -: 8];  tx_wait_n = 1'b1;
        end else if (i_tx_done) begin
          tx_wait_n = 1'b0;  tx_buf_n = tx_buf << 8;  tx_cnt_n = tx_cnt - 1'b1;
          if (tx_last && ret_dump) begin
            ph_n = 1'b0;
            reg_addr_n = dump_last ? '0 : o_reg_addr + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (rep_en) begin
      tx_buf_n = {rep_byte, {(SIZE-8){1'b0}}};  tx_cnt_n = TCW'(1);  tx_wait_n = 1'b0;  ret_dump_n = 1'b0;
    end else if (wrep_en) begin
      tx_buf_n = wrep_word;  tx_cnt_n = TCW'(BYTES);  tx_wait_n = 1'b0;  ret_dump_n = (state == S_DUMP);
    end
  end
endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
UART-driven debug sequencer for the MIPS core. It decodes single-byte commands from the UART receiver and performs four operations:
- loads the program into instruction memory,
- runs the core until halt,
- single-steps the core,
- dumps the register file back over the UART transmitter.

It owns the pipeline stall and pipeline-reset controls and sits between the UART rx/tx pair and the mips core's debug hooks.

Parameters:
SIZE, 32, datapath/word width in bits (fixed multiple of 8; 4 bytes per word)
MAX_INSTRUCTION, 64, max words accepted by a load
NUM_REGISTERS, 32, register file entries dumped
ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction memory word-address width
REG_ADDR_WIDTH, $clog2(NUM_REGISTERS), register index width
TIMEOUT_CYCLES, 1000000, inter-byte load timeout (used only with DEBUG_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock; single clock domain
i_rst  in  1  reset, asynchronous, active-high
i_rx_data  in  8  received UART byte
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_start  out  1  one-cycle pulse, start transmit
i_tx_done  in  1  one-cycle pulse, byte fully sent
o_imem_we  out  1  instruction memory write strobe
o_imem_addr  out  ADDR_WIDTH  word address
o_imem_wdata  out  SIZE  word data
o_reg_addr  out  REG_ADDR_WIDTH  register file debug read index
i_reg_data  in  SIZE  register read data, valid the cycle after o_reg_addr
i_pc  in  SIZE  current PC
i_halt  in  1  core executed halt instruction (level)
o_cpu_stall  out  1  freeze pipeline
o_cpu_rst  out  1  one-cycle pipeline/PC reset pulse
o_prog_loaded  out  1  valid program present
o_state  out  3  0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 DUMP, 5 TX

Behaviour:
- Reset values:
  - o_cpu_stall=1; every other output=0; state IDLE.
  - Reset mid-operation aborts it, drops any pending tx, clears o_prog_loaded.
- All outputs are registered.
- o_cpu_stall=1 in every state except RUN and the single STEP execute cycle.
- TX handshake:
  - o_tx_start pulses one cycle with o_tx_data stable from that cycle until i_tx_done.
  - The next byte is never started before i_tx_done.
  - Word replies are SIZE/8 bytes, MSB first.
  - Rx bytes arriving in TX or DUMP are discarded.
- IDLE dispatches on i_rx_done:
  - 'L' 0x4C -> LOAD
  - 'R' 0x52 -> RUN
  - 'S' 0x53 -> STEP
  - 'D' 0x44 -> DUMP
  - anything else -> reply 0xEE.
- LOAD:
  - First byte is word count N. If N==0 or N>MAX_INSTRUCTION: reply 0xEE, return to IDLE, o_prog_loaded unchanged.
  - On a valid N: o_cpu_rst pulses one cycle and o_prog_loaded is cleared.
  - Data bytes are assembled MSB first. On the 4th byte of word k, the next cycle has o_imem_we=1 for one cycle, o_imem_addr=k, o_imem_wdata=word.
  - After word N-1 is written: o_prog_loaded=1, reply 0x4B ('K').
- RUN:
  - If !o_prog_loaded: reply 0xEE.
  - Otherwise o_cpu_stall=0 until either i_halt is sampled 1, or rx byte 'P' 0x50 arrives (other bytes ignored).
  - o_cpu_stall is then 1 on the next cycle; reply i_pc sampled one cycle after stall asserts.
  - If i_halt is already 1 on entry: zero run cycles, reply PC.
- STEP:
  - If !o_prog_loaded or i_halt: reply 0xEE.
  - Otherwise o_cpu_stall=0 for exactly one cycle, then one settle cycle, then reply i_pc.
- DUMP:
  - For r=0..NUM_REGISTERS-1: drive o_reg_addr=r, wait one cycle, latch i_reg_data, send the word.
  - Total 4*NUM_REGISTERS bytes, ascending order. o_reg_addr returns to 0 after the dump.
- After any reply completes, return to IDLE.
- i_halt while not in RUN is ignored.

Optional Feature:
DEBUG_TIMEOUT_EN:
- Defined: in LOAD, a counter reloads on each i_rx_done. If TIMEOUT_CYCLES cycles pass with no byte, the load aborts: o_prog_loaded=0, reply 0xEF, return to IDLE. A partially written imem is left as is.
- Undefined: LOAD waits indefinitely; no counter logic is synthesized.

Test Plan:
- Load: 'L',0x02,12 34 56 78,DE AD BE EF -> o_cpu_rst pulse; imem writes (0,0x12345678) then (1,0xDEADBEEF), one cycle each; tx 0x4B; o_prog_loaded=1.
- Bad commands: 'R' before any load -> tx 0xEE, stall stays 1. 'L',0x00 -> 0xEE. 'L',0x41 with MAX_INSTRUCTION=64 -> 0xEE. 'Z' -> 0xEE.
- Run to halt: after load, 'R'; force i_halt=1 at cycle 20 with i_pc=0x00000010 -> stall 0 for 20 cycles, then 1; tx 00 00 00 10.
- Pause: 'R' then rx 'P' -> stall reasserts the next cycle; current PC returned.
- Step: 'S' with i_pc=0x4 -> o_cpu_stall low exactly one cycle; tx 00 00 00 04.
- Dump and reset: 'D' with reg[r]=r*0x01010101 -> 128 bytes, reg0..reg31 in order, each MSB first, one tx_start per i_tx_done. Assert i_rst after 2 bytes of a load -> all outputs at reset values immediately; o_prog_loaded=0. With DEBUG_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop after 3 data bytes -> tx 0xEF at cycle 100.
